// File: rtl/image_frame_feeder.sv
// Ping-pong frame buffer: accepts host pixels into two 28x28 banks and replays each full bank
// as a gap-free raster burst with enforced inter-frame spacing. Optional macro: FEEDER_WAIT_DONE_EN.
module image_frame_feeder #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int FRAME_GAP = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       frame_start,
    input  logic       done_in,
    output logic       busy,
    output logic       frame_err
);

    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(N);
    localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP - 1);

    localparam logic [1:0] B_FREE    = 2'd0;
    localparam logic [1:0] B_FULL    = 2'd1;
    localparam logic [1:0] B_READING = 2'd2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STREAM    = 2'd1;
    localparam logic [1:0] S_GAP       = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [7:0]        mem0 [N];
    logic [7:0]        mem1 [N];
    logic [1:0]        flag0, flag1;
    logic [1:0]        wr_flag, rd_flag;
    logic              wr_bank, rd_bank;
    logic              rdy_en;
    logic [ADDR_W-1:0] wr_cnt, rd_addr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        state;
    logic              full_p1, full_bank_p1;
    logic              accept, wr_last, wr_bad;
    logic              rd_start, rd_free, done_ok;

    assign wr_flag  = wr_bank ? flag1 : flag0;
    assign rd_flag  = rd_bank ? flag1 : flag0;
    assign s_ready  = rdy_en && (wr_flag == B_FREE);
    assign accept   = s_valid && s_ready;
    assign wr_last  = accept && (wr_cnt == LAST_ADDR);
    assign wr_bad   = accept && s_last && (wr_cnt != LAST_ADDR);
    assign rd_start = (state == S_IDLE) && (rd_flag == B_FULL);
    assign rd_free  = (state == S_GAP) && (gap_cnt == '0);
    assign busy     = (state != S_IDLE);

`ifdef FEEDER_WAIT_DONE_EN
    localparam logic [1:0] S_AFTER_GAP = S_WAIT_DONE;
    logic done_seen;

    // Remembers a network completion seen since the current burst began
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_seen <= 1'b0;
        end else if (rd_start) begin
            done_seen <= 1'b0;
        end else if (state == S_WAIT_DONE && done_ok) begin
            done_seen <= 1'b0;
        end else if (done_in) begin
            done_seen <= 1'b1;
        end
    end

    assign done_ok = done_in || done_seen;
`else
    localparam logic [1:0] S_AFTER_GAP = S_IDLE;
    logic unused_done;

    assign unused_done = done_in;
    assign done_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (accept && !wr_bad) begin
            if (wr_bank) begin
                mem1[wr_cnt] <= s_data;
            end else begin
                mem0[wr_cnt] <= s_data;
            end
        end
    end

    // Write side: completion is registered once so the FULL flag lands one edge after the last accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en       <= 1'b0;
            wr_bank      <= 1'b0;
            wr_cnt       <= '0;
            full_p1      <= 1'b0;
            full_bank_p1 <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            frame_err <= wr_bad;
            full_p1   <= wr_last;
            if (wr_last) begin
                full_bank_p1 <= wr_bank;
                wr_bank      <= ~wr_bank;
                wr_cnt       <= '0;
            end else if (wr_bad) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Writer and reader never target the same bank in one cycle, so updates cannot collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag0 <= B_FREE;
            flag1 <= B_FREE;
        end else begin
            if (full_p1 && !full_bank_p1) begin
                flag0 <= B_FULL;
            end else if (rd_start && !rd_bank) begin
                flag0 <= B_READING;
            end else if (rd_free && !rd_bank) begin
                flag0 <= B_FREE;
            end
            if (full_p1 && full_bank_p1) begin
                flag1 <= B_FULL;
            end else if (rd_start && rd_bank) begin
                flag1 <= B_READING;
            end else if (rd_free && rd_bank) begin
                flag1 <= B_FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            gap_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        rd_addr <= '0;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    out_valid   <= 1'b1;
                    frame_start <= (rd_addr == '0);
                    out_data    <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
                    if (rd_addr == LAST_ADDR) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_GAP: begin
                    // Bank release happens on the first idle cycle after the burst
                    if (gap_cnt == '0) begin
                        rd_bank <= ~rd_bank;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_AFTER_GAP;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (done_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
